packet_buffer_writer: RTL and testbench
=======================================

// Module: packet_buffer_writer
// PURPOSE
//   Receive-side counterpart of the memory read streamer: captures a framed byte stream into a circular
//   packet buffer RAM and publishes each completed frame as a [pkt_start, pkt_end) address range.
//   Sits between the dibit->byte converter (RMII RX path) and the packet buffer RAM.
//   Frames that overflow free space or exceed MAX_PKT_LEN, and aborted frames, are discarded without
//   being published.
// PARAMETERS
//   RAM_SIZE     PACKET_BUFFER_SIZE  buffer depth in bytes; power of 2; AW = clog2(RAM_SIZE)
//   MAX_PKT_LEN  1536                max bytes per frame; longer frames are dropped
// PORTS
//   clk             in   1         clock
//   reset           in   1         synchronous, active-high
//   in_ready        in   1         byte valid on in this cycle
//   in              in   BYTE_LEN  data byte
//   in_done         in   1         end-of-frame pulse; if coincident with in_ready, that byte is the last one
//   in_abort        in   1         discard the current frame (e.g. bad FCS)
//   read_ptr        in   AW        consumer's oldest unreleased byte; slots in [read_ptr, wr_ptr) are unusable
//   ram_write_req   out  1         RAM write strobe
//   ram_write_addr  out  AW        RAM write address
//   ram_write_val   out  BYTE_LEN  RAM write data
//   pkt_valid       out  1         one-cycle pulse: a frame has been committed
//   pkt_start       out  AW        first byte address of the committed frame (held until the next pkt_valid)
//   pkt_end         out  AW        one past the last byte, mod RAM_SIZE (held)
//   overflow        out  1         one-cycle pulse: current frame dropped (full or too long)
//   busy            out  1         state != IDLE
// BEHAVIOUR
//   - Reset: all outputs 0; wr_ptr = commit_ptr = 0; len = 0; state IDLE.
//     A partial frame in progress at reset is discarded silently.
//   - Address arithmetic is AW-bit modulo (natural wrap).
//     full = (wr_ptr + 1 == read_ptr); one slot is always left empty.
//   - Priority each cycle: in_abort > in_ready > in_done (in_done still ends the frame after the
//     coincident byte is handled).
//   - States:
//     - IDLE: in_ready -> write byte, go RECV. in_done/in_abort alone -> ignored.
//     - RECV: in_ready and !full and len < MAX_PKT_LEN -> write at wr_ptr, wr_ptr++, len++.
//       in_ready and (full or len == MAX_PKT_LEN) -> no write, wr_ptr <= commit_ptr, overflow pulse,
//       go DROP (or IDLE if in_done in the same cycle).
//       in_done -> commit: pkt_start <= commit_ptr, pkt_end <= final wr_ptr, commit_ptr <= final wr_ptr,
//       pkt_valid pulse, len <= 0, go IDLE.
//       in_abort -> wr_ptr <= commit_ptr, len <= 0, go IDLE; no pulse.
//     - DROP: bytes ignored, no writes; in_done or in_abort -> len <= 0, go IDLE. No pkt_valid.
//   - The full check in IDLE on the first byte is identical to RECV: a full buffer sends the frame
//     straight to DROP with an overflow pulse.
//   - Latency: ram_write_* registered, asserted the cycle after the accepted in_ready.
//     pkt_valid is registered and asserted the cycle after in_done, coincident with the last byte's
//     write at the latest. The consumer reads no earlier than the cycle after pkt_valid.
//   - A zero-length frame (no byte ever accepted) is never published.
//   - Back-to-back frames: in_ready in the cycle after in_done starts a new frame at the new commit_ptr.
//   - read_ptr may change on any cycle; full is evaluated combinationally against the current value.
// TESTING
//   (RAM_SIZE=16, MAX_PKT_LEN=8)
//   1. Reset, read_ptr=0; bytes 0xA0..0xA4, in_done with the last one
//      -> writes addr 0..4; pkt_valid with start=0, end=5.
//   2. Two back-to-back 3-byte frames with no gap -> pkt (0,3) then (3,6); writes contiguous.
//   3. read_ptr=6, commit_ptr=0; send 7 bytes -> 5 written (addr 0..4); overflow pulses on the 6th byte;
//      no pkt_valid; next frame starts at addr 0.
//   4. 9-byte frame with read_ptr far away -> overflow on the 9th byte; wr_ptr rewinds; no pkt_valid.
//   5. in_abort after 4 bytes, then a 2-byte frame -> pkt (0,2); aborted bytes overwritten.
//   6. Wrap: commit_ptr=14, read_ptr=10, 4-byte frame -> writes 14,15,0,1; pkt (14,2).
//      Then reset mid-frame -> outputs 0, busy=0, no pkt_valid.

Source files
------------

// File: rtl/packet_buffer_writer.sv
// packet_buffer_writer
//   Captures a framed byte stream (from the RMII RX dibit->byte converter)
//   into a circular packet buffer RAM. Each completed frame is published as
//   a [pkt_start, pkt_end) address range. Frames that run out of free space,
//   exceed MAX_PKT_LEN, or are aborted are discarded and never published.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_ready_i, in_i    byte strobe and data
//   in_done_i           end of frame (a coincident byte is the last one)
//   in_abort_i          discard the frame in progress
//   read_ptr_i          consumer's oldest unreleased byte
//   ram_write_*_o       registered RAM write port
//   pkt_valid_o         one-cycle pulse when a frame is committed
//   pkt_start_o/end_o   committed frame range, held until the next commit
//   overflow_o          one-cycle pulse when the current frame is dropped
//   busy_o              a frame is being received or dropped
module packet_buffer_writer #(
  parameter int RAM_SIZE    = 2048,
  parameter int MAX_PKT_LEN = 1536,
  parameter int BYTE_LEN    = 8,
  localparam int AW         = $clog2(RAM_SIZE),
  localparam int LW         = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_ready_i,
  input  logic [BYTE_LEN-1:0] in_i,
  input  logic                in_done_i,
  input  logic                in_abort_i,
  input  logic [AW-1:0]       read_ptr_i,
  output logic                ram_write_req_o,
  output logic [AW-1:0]       ram_write_addr_o,
  output logic [BYTE_LEN-1:0] ram_write_val_o,
  output logic                pkt_valid_o,
  output logic [AW-1:0]       pkt_start_o,
  output logic [AW-1:0]       pkt_end_o,
  output logic                overflow_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       commit_q, commit_d;
  logic [LW-1:0]       len_q, len_d;
  logic                wr_req_q, wr_req_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [BYTE_LEN-1:0] wr_val_q, wr_val_d;
  logic                pv_q, pv_d;
  logic [AW-1:0]       ps_q, ps_d;
  logic [AW-1:0]       pe_q, pe_d;
  logic                ovf_q, ovf_d;

  logic full;
  logic reject;

  // One slot always stays empty so wr_ptr == read_ptr means "empty".
  assign full   = (wr_ptr_q + AW'(1)) == read_ptr_i;
  assign reject = in_ready_i && (full || (len_q == LW'(MAX_PKT_LEN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      commit_q  <= '0;
      len_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
      pv_q      <= 1'b0;
      ps_q      <= '0;
      pe_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      commit_q  <= commit_d;
      len_q     <= len_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_val_q  <= wr_val_d;
      pv_q      <= pv_d;
      ps_q      <= ps_d;
      pe_q      <= pe_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    len_d     = len_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_val_d  = wr_val_q;
    pv_d      = 1'b0;
    ps_d      = ps_q;
    pe_d      = pe_q;
    ovf_d     = 1'b0;

    case (state_q)
      // IDLE and RECV share one path: in IDLE len is 0 and wr_ptr equals
      // commit_ptr, so abort is a no-op and a lone in_done publishes nothing.
      S_IDLE, S_RECV: begin
        if (in_abort_i) begin
          wr_ptr_d = commit_q;
          len_d    = '0;
          state_d  = S_IDLE;
        end else begin
          if (reject) begin
            ovf_d    = 1'b1;
            wr_ptr_d = commit_q;
            len_d    = '0;
            state_d  = in_done_i ? S_IDLE : S_DROP;
          end else if (in_ready_i) begin
            wr_req_d  = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_val_d  = in_i;
            wr_ptr_d  = wr_ptr_q + AW'(1);
            len_d     = len_q + LW'(1);
            state_d   = S_RECV;
          end
          // Commit uses the post-byte pointer so a coincident last byte is included.
          if (in_done_i && !reject && (len_d != '0)) begin
            pv_d     = 1'b1;
            ps_d     = commit_q;
            pe_d     = wr_ptr_d;
            commit_d = wr_ptr_d;
            len_d    = '0;
            state_d  = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (in_abort_i || in_done_i) begin
          len_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_write_req_o  = wr_req_q;
  assign ram_write_addr_o = wr_addr_q;
  assign ram_write_val_o  = wr_val_q;
  assign pkt_valid_o      = pv_q;
  assign pkt_start_o      = ps_q;
  assign pkt_end_o        = pe_q;
  assign overflow_o       = ovf_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_packet_buffer_writer.sv
module tb_packet_buffer_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ready_i;
  logic [7:0] in_i;
  logic       in_done_i;
  logic       in_abort_i;
  logic [3:0] read_ptr_i;
  logic       ram_write_req_o;
  logic [3:0] ram_write_addr_o;
  logic [7:0] ram_write_val_o;
  logic       pkt_valid_o;
  logic [3:0] pkt_start_o;
  logic [3:0] pkt_end_o;
  logic       overflow_o;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  packet_buffer_writer #(.RAM_SIZE(16), .MAX_PKT_LEN(8), .BYTE_LEN(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready_i       (in_ready_i),
    .in_i             (in_i),
    .in_done_i        (in_done_i),
    .in_abort_i       (in_abort_i),
    .read_ptr_i       (read_ptr_i),
    .ram_write_req_o  (ram_write_req_o),
    .ram_write_addr_o (ram_write_addr_o),
    .ram_write_val_o  (ram_write_val_o),
    .pkt_valid_o      (pkt_valid_o),
    .pkt_start_o      (pkt_start_o),
    .pkt_end_o        (pkt_end_o),
    .overflow_o       (overflow_o),
    .busy_o           (busy_o)
  );

  // One vector = inputs for one cycle plus the outputs expected right after that edge.
  typedef struct {
    logic       rst, rdy;
    logic [7:0] din;
    logic       done, abt;
    logic [3:0] rp;
    logic       req;
    logic [3:0] addr;
    logic [7:0] val;
    logic       pv;
    logic [3:0] ps, pe;
    logic       ovf, busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic rdy, input logic [7:0] din,
                     input logic done, input logic abt, input logic [3:0] rp,
                     input logic req, input logic [3:0] addr, input logic [7:0] val,
                     input logic pv, input logic [3:0] ps, input logic [3:0] pe,
                     input logic ovf, input logic busy);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.din = din; v.done = done; v.abt = abt; v.rp = rp;
    v.req = req; v.addr = addr; v.val = val; v.pv = pv; v.ps = ps; v.pe = pe;
    v.ovf = ovf; v.busy = busy;
    vq.push_back(v);
  endtask

  // accepted byte: written at addr one cycle later
  task automatic w(input logic [7:0] din, input logic done, input logic [3:0] rp,
                   input logic [3:0] addr, input logic pv, input logic [3:0] ps,
                   input logic [3:0] pe, input logic busy);
    add(1'b0, 1'b1, din, done, 1'b0, rp, 1'b1, addr, din, pv, ps, pe, 1'b0, busy);
  endtask

  task automatic rst_v(input logic [3:0] rp);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, rp, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset = v.rst; in_ready_i = v.rdy; in_i = v.din;
    in_done_i = v.done; in_abort_i = v.abt; read_ptr_i = v.rp;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [3:0] ga, ea;
    logic [7:0] gv, ev;
    // write address/data only matter while the strobe is expected
    ga = v.req ? ram_write_addr_o : 4'd0;
    gv = v.req ? ram_write_val_o  : 8'd0;
    ea = v.req ? v.addr : 4'd0;
    ev = v.req ? v.val  : 8'd0;
    n_chk++;
    if ({ram_write_req_o, ga, gv, pkt_valid_o, pkt_start_o, pkt_end_o, overflow_o, busy_o} !==
        {v.req, ea, ev, v.pv, v.ps, v.pe, v.ovf, v.busy}) begin
      n_fail++;
      $display("FAIL %s: got req=%0b addr=%0d val=%h pv=%0b start=%0d end=%0d ovf=%0b busy=%0b; required req=%0b addr=%0d val=%h pv=%0b start=%0d end=%0d ovf=%0b busy=%0b",
               name, ram_write_req_o, ga, gv, pkt_valid_o, pkt_start_o, pkt_end_o, overflow_o, busy_o,
               v.req, ea, ev, v.pv, v.ps, v.pe, v.ovf, v.busy);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; in_ready_i = 1'b0; in_i = 8'h00;
    in_done_i = 1'b0; in_abort_i = 1'b0; read_ptr_i = 4'd0;

    // 1: simple 5-byte frame
    rst_v(4'd0);
    for (int i = 0; i < 4; i++) w(8'(160 + i), 1'b0, 4'd0, 4'(i), 1'b0, 4'd0, 4'd0, 1'b1);
    w(8'hA4, 1'b1, 4'd0, 4'd4, 1'b1, 4'd0, 4'd5, 1'b0);
    // 2: back-to-back 3-byte frames
    rst_v(4'd0);
    w(8'hB0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    w(8'hB1, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1);
    w(8'hB2, 1'b1, 4'd0, 4'd2, 1'b1, 4'd0, 4'd3, 1'b0);
    w(8'hC0, 1'b0, 4'd0, 4'd3, 1'b0, 4'd0, 4'd3, 1'b1);
    w(8'hC1, 1'b0, 4'd0, 4'd4, 1'b0, 4'd0, 4'd3, 1'b1);
    w(8'hC2, 1'b1, 4'd0, 4'd5, 1'b1, 4'd3, 4'd6, 1'b0);
    // 3: buffer full on the 6th byte, done while dropping
    rst_v(4'd6);
    for (int i = 0; i < 5; i++) w(8'(208 + i), 1'b0, 4'd6, 4'(i), 1'b0, 4'd0, 4'd0, 1'b1);
    add(1'b0, 1'b1, 8'hD5, 1'b0, 1'b0, 4'd6, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'hD6, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    w(8'hE0, 1'b1, 4'd6, 4'd0, 1'b1, 4'd0, 4'd1, 1'b0);
    // 4: 9-byte frame with MAX=8, done on the rejected byte
    for (int i = 0; i < 8; i++) w(8'(240 + i), 1'b0, 4'd0, 4'(1 + i), 1'b0, 4'd0, 4'd1, 1'b1);
    add(1'b0, 1'b1, 8'hF8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    w(8'h5A, 1'b1, 4'd0, 4'd1, 1'b1, 4'd1, 4'd2, 1'b0);
    // 5: abort after 4 bytes, then a 2-byte frame overwrites them
    rst_v(4'd0);
    for (int i = 0; i < 4; i++) w(8'(144 + i), 1'b0, 4'd0, 4'(i), 1'b0, 4'd0, 4'd0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    w(8'h60, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    w(8'h61, 1'b1, 4'd0, 4'd1, 1'b1, 4'd0, 4'd2, 1'b0);
    // abort beats a coincident byte; lone in_done in IDLE publishes nothing
    w(8'h70, 1'b0, 4'd0, 4'd2, 1'b0, 4'd0, 4'd2, 1'b1);
    add(1'b0, 1'b1, 8'h71, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
    w(8'h72, 1'b1, 4'd0, 4'd2, 1'b1, 4'd2, 4'd3, 1'b0);
    // full on the very first byte of a frame
    rst_v(4'd1);
    add(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    // 6: two 7-byte frames bring commit_ptr to 14, then a wrapping frame
    rst_v(4'd15);
    for (int i = 0; i < 7; i++)
      w(8'(16 + i), i == 6, 4'd15, 4'(i), i == 6, 4'd0, (i == 6) ? 4'd7 : 4'd0, i != 6);
    for (int i = 0; i < 7; i++)
      w(8'(32 + i), i == 6, 4'd15, 4'(7 + i), i == 6, (i == 6) ? 4'd7 : 4'd0, (i == 6) ? 4'd14 : 4'd7, i != 6);
    for (int i = 0; i < 4; i++)
      w(8'(48 + i), i == 3, 4'd10, 4'((14 + i) % 16), i == 3, (i == 3) ? 4'd14 : 4'd7, (i == 3) ? 4'd2 : 4'd14, i != 3);

    foreach (vq[k]) begin
      drive(vq[k]);
      check($sformatf("vec%0d", k), vq[k]);
    end

    // Reset in the middle of a frame (commit_ptr is 2 here), with a byte and done pending.
    add(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 4'd10, 1'b1, 4'd2, 8'h81, 1'b0, 4'd14, 4'd2, 1'b0, 1'b1);
    v = vq[$];
    drive(v); check("midframe_byte0", v);
    v.din = 8'h82; v.val = 8'h82; v.addr = 4'd3;
    drive(v); check("midframe_byte1", v);
    v.rst = 1'b1; v.din = 8'h83; v.done = 1'b1;
    v.req = 1'b0; v.pv = 1'b0; v.ps = 4'd0; v.pe = 4'd0; v.busy = 1'b0;
    drive(v); check("reset_midframe", v);
    v.rst = 1'b0; v.rdy = 1'b0; v.done = 1'b0;
    drive(v); check("after_reset_quiet", v);
    v.rdy = 1'b1; v.din = 8'h99; v.done = 1'b1;
    v.req = 1'b1; v.addr = 4'd0; v.val = 8'h99; v.pv = 1'b1; v.ps = 4'd0; v.pe = 4'd1;
    drive(v); check("after_reset_frame", v);
    v.rdy = 1'b0; v.done = 1'b0; v.req = 1'b0; v.pv = 1'b0;
    drive(v); check("pkt_valid_one_cycle", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
